id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 96 +++++++++
 rtl/id_stage_regfile_nx16.sv | 54 +++++
 rtl/id_stage.sv | 162 ++++++++++++++++
 tb/tb_id_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage and the ALU stage that consumes
// its outputs: opcode values, instruction field positions and default widths.
package id_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREG_DEF   = 8;
    localparam int REG_AW     = 3;
    localparam int INSTR_W    = 16;
    localparam int OP_W       = 4;

    // Instruction field LSB positions: [15:12] op, [11:9] rd, [8:6] rs1,
    // [5:3] rs2, [5:0] imm6.
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 6;

    // Opcodes; 0000-0111 are register-register ALU operations.
    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'h5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SLT  = 4'h7;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h8;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h9;
    localparam logic [OP_W-1:0] OP_LW   = 4'hA;
    localparam logic [OP_W-1:0] OP_SW   = 4'hB;

    // ALU operation codes driven to the next stage for non R-type ops.
    localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [OP_W-1:0] ALU_MOV = 4'h9;

    // Control decoded from the opcode alone.
    typedef struct packed {
        logic            valid;      // legal opcode; illegal ones become bubbles
        logic [OP_W-1:0] alu_op;
        logic            use_rs1;    // operand a comes from rs1
        logic            use_rs2;    // operand b comes from rs2
        logic            use_rd;     // rd is read as store data (SW)
        logic            b_imm;      // operand b is the sign-extended imm6
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } dec_t;

    function automatic dec_t decode_op(input logic [OP_W-1:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
                d.valid     = 1'b1;
                d.alu_op    = op;
                d.use_rs1   = 1'b1;
                d.use_rs2   = 1'b1;
                d.reg_write = 1'b1;
            end
            OP_ADDI: begin
                d.valid     = 1'b1;
                d.alu_op    = ALU_ADD;
                d.use_rs1   = 1'b1;
                d.b_imm     = 1'b1;
                d.reg_write = 1'b1;
            end
            OP_LW: begin
                d.valid     = 1'b1;
                d.alu_op    = ALU_ADD;
                d.use_rs1   = 1'b1;
                d.b_imm     = 1'b1;
                d.reg_write = 1'b1;
                d.mem_read  = 1'b1;
            end
            OP_SW: begin
                d.valid     = 1'b1;
                d.alu_op    = ALU_ADD;
                d.use_rs1   = 1'b1;
                d.use_rd    = 1'b1;
                d.b_imm     = 1'b1;
                d.mem_write = 1'b1;
            end
            OP_MOV: begin
                d.valid     = 1'b1;
                d.alu_op    = ALU_MOV;
                d.use_rs1   = 1'b1;
                d.reg_write = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_regfile_nx16.sv
// Register file: NREG x DATA_W, two combinational read ports, one write port.
// r0 always reads 0 and ignores writes; a read of the register being written
// this cycle returns the write data (write-through).
module regfile_nx16
    import id_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NREG];

    // Storage: cleared asynchronously, r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port A with r0 hard zero and write-through.
    always_comb begin
        rdata_a = mem[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    // Read port B with r0 hard zero and write-through.
    always_comb begin
        rdata_b = mem[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decodes the fetched instruction, reads and
// forwards operands, detects load-use hazards and registers the result into
// a single ID/EX bank.
//
// Handshake: an instruction transfers when in_valid & in_ready are both high
// at a rising edge; in_ready = ~stall_i & ~load_use (and low during reset).
// A transferred instruction is dropped if flush_i is high in the same cycle.
// out_valid marks the ID/EX bank as holding a real instruction; there is no
// downstream ready, stall_i is the only back-pressure.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               ex_reg_write,
    input  logic [REG_AW-1:0]  ex_rd,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    output logic [OP_W-1:0]    out_alu_op,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_reg_write,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic [DATA_W-1:0]  out_store_data
);

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM_W-1:0]  imm6;
    logic [DATA_W-1:0] imm_ext;
    dec_t              dec;

    logic [REG_AW-1:0] src_b;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] nxt_b;
    logic [DATA_W-1:0] nxt_store;
    logic              load_use;
    logic              load_bubble;

    assign op      = in_instr[OP_LSB  +: OP_W];
    assign rd      = in_instr[RD_LSB  +: REG_AW];
    assign rs1     = in_instr[RS1_LSB +: REG_AW];
    assign rs2     = in_instr[RS2_LSB +: REG_AW];
    assign imm6    = in_instr[IMM_LSB +: IMM_W];
    assign imm_ext = {{(DATA_W-IMM_W){imm6[IMM_W-1]}}, imm6};
    assign dec     = decode_op(op);

    // Port B serves rs2 for R-type and rd (store data) for SW; no opcode
    // needs both, so two read ports are enough.
    assign src_b = dec.use_rd ? rd : rs2;

    regfile_nx16 #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs1),
        .raddr_b (src_b),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // Operand forwarding: the younger EX/MEM result wins over write-back,
    // write-back over the register file; r0 is never forwarded.
    always_comb begin
        fwd_a = rf_a;
        if (ex_reg_write && (ex_rd == rs1) && (rs1 != '0)) begin
            fwd_a = ex_result;
        end else if (wb_we && (wb_rd == rs1) && (rs1 != '0)) begin
            fwd_a = wb_data;
        end

        fwd_b = rf_b;
        if (ex_reg_write && (ex_rd == src_b) && (src_b != '0)) begin
            fwd_b = ex_result;
        end else if (wb_we && (wb_rd == src_b) && (src_b != '0)) begin
            fwd_b = wb_data;
        end

        nxt_b     = dec.b_imm ? imm_ext : (dec.use_rs2 ? fwd_b : '0);
        nxt_store = dec.use_rd ? fwd_b : '0;
    end

    // Load-use: the load now in ID/EX has no data to forward yet, so a
    // dependent instruction must wait one cycle.
    always_comb begin
        load_use = 1'b0;
        if (in_valid && dec.valid && out_valid && out_mem_read && (out_rd != '0)) begin
            if (dec.use_rs1 && (out_rd == rs1)) begin
                load_use = 1'b1;
            end
            if ((dec.use_rs2 || dec.use_rd) && (out_rd == src_b)) begin
                load_use = 1'b1;
            end
        end
    end

    assign in_ready = rst_n & ~stall_i & ~load_use;

    // Flush beats stall; otherwise an unstalled cycle with no usable
    // instruction (hazard, nothing offered, illegal opcode) inserts a bubble.
    assign load_bubble = flush_i ||
                         (!stall_i && (load_use || !in_valid || !dec.valid));

    // ID/EX register bank; a bubble clears every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_alu_op     <= '0;
            out_a          <= '0;
            out_b          <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_store_data <= '0;
        end else if (load_bubble) begin
            out_valid      <= 1'b0;
            out_alu_op     <= '0;
            out_a          <= '0;
            out_b          <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_store_data <= '0;
        end else if (!stall_i) begin
            out_valid      <= 1'b1;
            out_alu_op     <= dec.alu_op;
            out_a          <= fwd_a;
            out_b          <= nxt_b;
            out_rd         <= rd;
            out_reg_write  <= dec.reg_write;
            out_mem_read   <= dec.mem_read;
            out_mem_write  <= dec.mem_write;
            out_store_data <= nxt_store;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: the driver pushes the expected ID/EX contents
// for every clocked cycle; a monitor pops and compares one entry per cycle.
module tb_id_stage;

    localparam int VW = 59;

    // Compare masks over {valid, alu_op, a, b, rd, rw, mr, mw, store_data}.
    localparam logic [VW-1:0] M_ALL  = '1;
    localparam logic [VW-1:0] M_NOSD = {{(VW-16){1'b1}}, 16'h0};
    localparam logic [VW-1:0] B_FLD  = {21'h0, 16'hFFFF, 22'h0};
    localparam logic [VW-1:0] M_MOV  = M_NOSD & ~B_FLD;
    localparam logic [VW-1:0] M_BUB  = {1'b1, 4'h0, 16'h0, 16'h0, 3'h0, 3'b111, 16'h0};
    localparam logic [VW-1:0] BUB    = '0;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        stall_i;
    logic        flush_i;
    logic        ex_reg_write;
    logic [2:0]  ex_rd;
    logic [15:0] ex_result;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        out_valid;
    logic [3:0]  out_alu_op;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [2:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [15:0] out_store_data;

    int n_chk;
    int n_fail;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] mask_q[$];
    string         name_q[$];

    // Pending forwarding/write-back values applied by the next drive call.
    logic        p_ex_w;
    logic [2:0]  p_ex_rd;
    logic [15:0] p_ex_res;
    logic        p_wb_w;
    logic [2:0]  p_wb_rd;
    logic [15:0] p_wb_d;

    logic [VW-1:0] e_add;

    id_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_ready       (in_ready),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .ex_reg_write   (ex_reg_write),
        .ex_rd          (ex_rd),
        .ex_result      (ex_result),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_alu_op     (out_alu_op),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_store_data (out_store_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [5:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [VW-1:0] ev(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [2:0] rd,
                                         input logic rw, input logic mr, input logic mw,
                                         input logic [15:0] sd);
        return {1'b1, op, a, b, rd, rw, mr, mw, sd};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fwd(input logic exw, input logic [2:0] exrd, input logic [15:0] exres,
                           input logic wbw, input logic [2:0] wbrd, input logic [15:0] wbd);
        p_ex_w = exw; p_ex_rd = exrd; p_ex_res = exres;
        p_wb_w = wbw; p_wb_rd = wbrd; p_wb_d = wbd;
    endtask

    // One clocked cycle: apply inputs at negedge, check in_ready, queue the
    // expected ID/EX contents after the coming rising edge.
    task automatic drive(input string name, input logic v, input logic [15:0] ins,
                         input logic st, input logic fl, input logic erdy,
                         input logic [VW-1:0] e, input logic [VW-1:0] m);
        @(negedge clk);
        in_valid = v; in_instr = ins; stall_i = st; flush_i = fl;
        ex_reg_write = p_ex_w; ex_rd = p_ex_rd; ex_result = p_ex_res;
        wb_we = p_wb_w; wb_rd = p_wb_rd; wb_data = p_wb_d;
        set_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #1;
        chk({name, "_in_ready"}, in_ready, erdy);
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(name);
        @(posedge clk);
    endtask

    // Scoreboard monitor
    initial begin
        logic [VW-1:0] e;
        logic [VW-1:0] m;
        logic [VW-1:0] act;
        string         nm;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                m  = mask_q.pop_front();
                nm = name_q.pop_front();
                act = {out_valid, out_alu_op, out_a, out_b, out_rd, out_reg_write,
                       out_mem_read, out_mem_write, out_store_data};
                n_chk++;
                if ((act & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: got %0h expected %0h (mask %0h)", nm, act, e, m);
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b1;
        in_valid = 1'b0; in_instr = '0; stall_i = 1'b0; flush_i = 1'b0;
        ex_reg_write = 1'b0; ex_rd = '0; ex_result = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        set_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #3 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_a", out_a, 0);
        chk("reset_out_ctrl", {out_reg_write, out_mem_read, out_mem_write}, 0);
        chk("reset_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write-back of r3, then a read of it.
        set_fwd(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
        drive("wb_r3_idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, BUB, M_BUB);
        drive("add_r1_r3_r3", 1'b1, enc_r(4'h0, 3'd1, 3'd3, 3'd3), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h1234, 16'h1234, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        // Write-through: r2 written in the same cycle it is read.
        set_fwd(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h0BCD);
        drive("and_wb_through", 1'b1, enc_r(4'h2, 3'd7, 3'd2, 3'd3), 1'b0, 1'b0, 1'b1,
              ev(4'h2, 16'h0BCD, 16'h1234, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        // EX beats WB for the same source register.
        set_fwd(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 16'h0055);
        drive("sub_ex_over_wb", 1'b1, enc_r(4'h1, 3'd4, 3'd2, 3'd0), 1'b0, 1'b0, 1'b1,
              ev(4'h1, 16'h00AA, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        drive("or_r2_written", 1'b1, enc_r(4'h3, 3'd5, 3'd2, 3'd2), 1'b0, 1'b0, 1'b1,
              ev(4'h3, 16'h0055, 16'h0055, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);

        // Sign-extended immediate and r0 behaviour.
        drive("addi_imm_3f", 1'b1, enc_i(4'h8, 3'd1, 3'd0, 6'h3F), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0000, 16'hFFFF, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        set_fwd(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hBEEF);
        drive("xor_wb_r0", 1'b1, enc_r(4'h4, 3'd6, 3'd0, 3'd3), 1'b0, 1'b0, 1'b1,
              ev(4'h4, 16'h0000, 16'h1234, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        set_fwd(1'b1, 3'd0, 16'h7777, 1'b0, 3'd0, 16'h0);
        drive("add_r0_r0", 1'b1, enc_r(4'h0, 3'd2, 3'd0, 3'd0), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);

        // Load-use: one bubble, in_ready low once, then the ADD issues.
        set_fwd(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h0011);
        drive("wb_r1_idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, BUB, M_BUB);
        drive("lw_r5", 1'b1, enc_i(4'hA, 3'd5, 3'd1, 6'h02), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0011, 16'h0002, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0), M_NOSD);
        drive("load_use_bubble", 1'b1, enc_r(4'h0, 3'd6, 3'd5, 3'd1), 1'b0, 1'b0, 1'b0,
              BUB, M_BUB);
        set_fwd(1'b1, 3'd5, 16'h0ABC, 1'b0, 3'd0, 16'h0);
        drive("load_use_reissue", 1'b1, enc_r(4'h0, 3'd6, 3'd5, 3'd1), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0ABC, 16'h0011, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);

        // Store, move and an illegal opcode.
        drive("sw_r3", 1'b1, enc_i(4'hB, 3'd3, 3'd1, 6'h3C), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0011, 16'hFFFC, 3'd3, 1'b0, 1'b0, 1'b1, 16'h1234), M_ALL);
        drive("mov_r7_r3", 1'b1, enc_r(4'h9, 3'd7, 3'd3, 3'd0), 1'b0, 1'b0, 1'b1,
              ev(4'h9, 16'h1234, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0), M_MOV);
        drive("illegal_op", 1'b1, 16'hC000, 1'b0, 1'b0, 1'b1, BUB, M_BUB);

        // Stall holds outputs; flush overrides stall and load-use.
        e_add = ev(4'h0, 16'h1234, 16'h1234, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
        drive("add_before_stall", 1'b1, enc_r(4'h0, 3'd1, 3'd3, 3'd3), 1'b0, 1'b0, 1'b1,
              e_add, M_NOSD);
        for (int i = 0; i < 3; i++) begin
            drive("stall_hold", 1'b1, enc_r(4'h1, 3'd4, 3'd2, 3'd0), 1'b1, 1'b0, 1'b0,
                  e_add, M_NOSD);
        end
        drive("stall_and_flush", 1'b1, enc_r(4'h1, 3'd4, 3'd2, 3'd0), 1'b1, 1'b1, 1'b0,
              BUB, M_BUB);
        drive("flush_drop", 1'b1, enc_r(4'h0, 3'd1, 3'd3, 3'd3), 1'b0, 1'b1, 1'b1,
              BUB, M_BUB);
        drive("lw_r5_again", 1'b1, enc_i(4'hA, 3'd5, 3'd1, 6'h02), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0011, 16'h0002, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0), M_NOSD);
        drive("flush_over_load_use", 1'b1, enc_r(4'h0, 3'd6, 3'd5, 3'd1), 1'b0, 1'b1, 1'b0,
              BUB, M_BUB);
        drive("add_after_flush", 1'b1, enc_r(4'h0, 3'd6, 3'd5, 3'd1), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0000, 16'h0011, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);

        // Asynchronous reset in the middle of a stall.
        drive("or_before_reset", 1'b1, enc_r(4'h3, 3'd5, 3'd2, 3'd2), 1'b0, 1'b0, 1'b1,
              ev(4'h3, 16'h0055, 16'h0055, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        @(negedge clk);
        in_valid = 1'b1; in_instr = enc_r(4'h0, 3'd1, 3'd3, 3'd3); stall_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", {out_alu_op, out_a, out_b, out_rd, out_store_data}, 0);
        chk("async_rst_ctrl", {out_reg_write, out_mem_read, out_mem_write}, 0);
        chk("async_rst_in_ready", in_ready, 0);
        @(negedge clk);
        stall_i = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        drive("rf_cleared_r3", 1'b1, enc_r(4'h0, 3'd1, 3'd3, 3'd3), 1'b0, 1'b0, 1'b1,
              ev(4'h0, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        drive("rf_cleared_r2", 1'b1, enc_r(4'h3, 3'd5, 3'd2, 3'd2), 1'b0, 1'b0, 1'b1,
              ev(4'h3, 16'h0000, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0), M_NOSD);
        drive("idle_end", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, BUB, M_BUB);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
